// File: rtl/fetch_pc_ctrl.sv
// IF1 PC sequencer: picks the next PC (+4, redirect, or trap), runs a single-outstanding
// instruction-memory request, and holds the returned instruction until decode takes it.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hFFFF_F000,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       current_pc_if1,
  output logic              pc_en,
  output logic [31:0]       next_pc_if1,
  input  logic              halt_i,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              trap_valid,
  input  logic [31:0]       trap_pc,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [31:0]       inst_pc,
  input  logic              inst_ready
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, VALID} state_t;

  state_t              state, state_nxt;
  logic                kill, kill_nxt;
  logic [31:0]         req_pc, req_pc_nxt;
  logic                pend, pend_nxt;
  logic [31:0]         pend_pc, pend_pc_nxt;
  logic                inst_valid_nxt;
  logic [INST_W-1:0]   inst_out_nxt;
  logic [31:0]         inst_pc_nxt;

  logic        evt_now, evt;
  logic [31:0] sel_pc, target;

  // A redirect seen during BOOT is parked in pend and replayed in the first REQ cycle.
  assign evt_now = trap_valid | redirect_valid;
  assign evt     = evt_now | ((state == REQ) & pend);
  assign sel_pc  = trap_valid ? trap_pc : (redirect_valid ? redirect_pc : pend_pc);
  assign target  = {sel_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BOOT;
      kill       <= 1'b0;
      req_pc     <= '0;
      pend       <= 1'b0;
      pend_pc    <= '0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_nxt;
      kill       <= kill_nxt;
      req_pc     <= req_pc_nxt;
      pend       <= pend_nxt;
      pend_pc    <= pend_pc_nxt;
      inst_valid <= inst_valid_nxt;
      inst_out   <= inst_out_nxt;
      inst_pc    <= inst_pc_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    kill_nxt       = kill;
    req_pc_nxt     = req_pc;
    pend_nxt       = pend;
    pend_pc_nxt    = pend_pc;
    inst_valid_nxt = inst_valid;
    inst_out_nxt   = inst_out;
    inst_pc_nxt    = inst_pc;
    pc_en          = 1'b0;
    next_pc_if1    = current_pc_if1;
    imem_req       = 1'b0;
    imem_addr      = current_pc_if1;
    case (state)
      BOOT: begin
        if (evt_now) begin
          pend_nxt    = 1'b1;
          pend_pc_nxt = target;
        end
        state_nxt = REQ;
      end
      REQ: begin
        imem_req = ~halt_i;
        pend_nxt = 1'b0;
        if (imem_req && imem_gnt) begin
          // Request is out either way; a same-cycle redirect marks its response as stale.
          pc_en       = 1'b1;
          next_pc_if1 = evt ? target : current_pc_if1 + 32'd4;
          req_pc_nxt  = current_pc_if1;
          kill_nxt    = evt;
          state_nxt   = WAIT;
        end else if (evt) begin
          pc_en       = 1'b1;
          next_pc_if1 = target;
        end
      end
      WAIT: begin
        if (evt) begin
          pc_en       = 1'b1;
          next_pc_if1 = target;
          kill_nxt    = 1'b1;
        end
        if (imem_rvalid) begin
          if (kill || evt) begin
            kill_nxt  = 1'b0;
            state_nxt = REQ;
          end else begin
            inst_out_nxt   = imem_rdata;
            inst_pc_nxt    = req_pc;
            inst_valid_nxt = 1'b1;
            state_nxt      = VALID;
          end
        end
      end
      VALID: begin
        if (evt) begin
          pc_en          = 1'b1;
          next_pc_if1    = target;
          inst_valid_nxt = 1'b0;
          state_nxt      = REQ;
        end else if (inst_ready) begin
          inst_valid_nxt = 1'b0;
          state_nxt      = REQ;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  a_rvalid_only_in_wait: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rvalid |-> state == WAIT);
  a_boot_pc: assert property (@(posedge clk) disable iff (!reset_n)
    state == BOOT |-> current_pc_if1 == RESET_PC);

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Sequencer for the IF1 program-counter register. It decides when the PC advances and what value it loads: sequential +4, branch/jump redirect, or trap vector. It also runs the single-outstanding-request handshake to instruction memory and holds the fetched instruction until decode accepts it. It sits between the PC register, the instruction memory port, and the decode stage.

Parameters:
RESET_PC, 32'hFFFF_F000, boot ROM base; the value the PC register holds out of reset. Used only for the bench's reference model and assertions.
INST_W, 32, instruction width.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
current_pc_if1  in  32  present PC register value
pc_en  out  1  PC register load enable
next_pc_if1  out  32  value for the PC register to load when pc_en=1
halt_i  in  1  suppresses new fetch requests (debug/hazard freeze)
redirect_valid  in  1  branch/jump taken (EX)
redirect_pc  in  32  redirect target
trap_valid  in  1  trap/exception entry (CSR)
trap_pc  in  32  trap vector
imem_req  out  1  fetch request
imem_addr  out  32  fetch address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid
imem_rdata  in  INST_W  response data
inst_valid  out  1  instruction held for decode
inst_out  out  INST_W  held instruction
inst_pc  out  32  PC of held instruction
inst_ready  in  1  decode accepts

Behaviour:
- Reset: clk and reset_n only; reset is asynchronous, active-low. On reset: state=BOOT, kill=0, imem_req=0, inst_valid=0, inst_out=0, inst_pc=0, pc_en=0. The FSM deasserts these registered outputs immediately on reset assertion, including mid-transaction. Any response arriving after reset is ignored.
- next_pc_if1 is combinational. It equals current_pc_if1 whenever pc_en=0.
- Target selection: trap_valid has priority over redirect_valid. The selected target has bits [1:0] forced to 0.
- Sequential increment: current_pc_if1+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Any redirect or trap, in any state except BOOT, asserts pc_en=1 and sets next_pc_if1 to the target in the same cycle. In BOOT, the event is latched and applied in the first REQ cycle.
- BOOT: one cycle with imem_req=0, then go to REQ.
- REQ:
  - imem_req = ~halt_i; imem_addr = current_pc_if1.
  - On imem_req & imem_gnt with no redirect/trap: pc_en=1, next_pc=PC+4, req_pc<=current_pc_if1, kill<=0, go to WAIT.
  - On gnt with a redirect/trap in the same cycle: load the target, go to WAIT with kill=1.
  - On a redirect/trap without gnt: load the target, stay in REQ.
  - The address may change between un-granted cycles.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with kill=1: drop the data, kill<=0, go to REQ.
  - On imem_rvalid with kill=0: inst_out<=imem_rdata, inst_pc<=req_pc, inst_valid<=1, go to VALID.
  - A redirect/trap in WAIT loads the PC and sets kill=1. If it coincides with rvalid, the response is dropped and the FSM goes to REQ.
- VALID:
  - inst_valid=1, and the held data stays stable while inst_ready=0.
  - On inst_ready: inst_valid<=0, go to REQ.
  - A redirect/trap in VALID: inst_valid<=0, load the PC, go to REQ, even if inst_ready is high the same cycle. Decode must treat that handshake as void because the redirect comes from a younger stage.
- At most one outstanding request. rvalid outside WAIT is ignored, and an assertion flags it.
- Throughput: 3 cycles per instruction minimum with zero-wait memory (REQ→WAIT→VALID).
- halt_i only gates imem_req in REQ. It does not kill outstanding or held instructions.

Test Plan:
- Reset then zero-wait memory: PC starts 0xFFFFF000 → inst_pc sequence 0xFFFFF000, 0xFFFFF004, 0xFFFFF008; inst_valid every 3rd cycle; pc_en high exactly on gnt cycles.
- Redirect in WAIT, redirect_pc=0x80000102: pc loads 0x80000100, pending response dropped (inst_valid stays 0), next imem_addr=0x80000100.
- trap_valid (0x00000200) and redirect_valid (0x1000) in the same cycle in REQ without gnt: next_pc_if1=0x200, state stays REQ, imem_addr=0x200 the next cycle.
- Backpressure: inst_ready=0 for 5 cycles in VALID → inst_out/inst_pc stable, imem_req=0, pc_en=0; on ready, state returns to REQ.
- Wrap: current_pc 0xFFFFFFFC granted → next_pc_if1=0x00000000.
- reset_n asserted in WAIT, rvalid arrives during reset → inst_valid=0; after release, BOOT, then imem_addr=0xFFFFF000.
